btn_debounce: RTL and testbench

//  Input conditioner placed directly upstream of the GPIO sequencing timer.

---
 rtl/btn_debounce_if.sv | 28 ++
 rtl/btn_debounce.sv | 169 ++++++++++++++++
 tb/tb_btn_debounce.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_if.sv
// ---------------------------------------------------------------------------
// btn_debounce_if
//   Signal bundle between the raw push-button pin and the debounce block.
//   master : drives btn_raw, observes the conditioned outputs (pin/bench side)
//   slave  : the debouncer itself
//   btn_raw        raw button pin, active-low, asynchronous
//   btn_clean      debounced level, active-low
//   press_pulse    1-cycle strobe when a press is accepted
//   release_pulse  1-cycle strobe when a release is accepted
//   long_pulse     1-cycle strobe on long press (0 when the feature is absent)
// ---------------------------------------------------------------------------
interface btn_debounce_if;
  logic btn_raw;
  logic btn_clean;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  modport master (
    output btn_raw,
    input  btn_clean, press_pulse, release_pulse, long_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_clean, press_pulse, release_pulse, long_pulse
  );
endinterface

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
//   Synchronises an asynchronous active-low push-button and debounces it with
//   a 4-state FSM. The debounced level feeds the GPIO sequencing timer's btn
//   input, and one-cycle press/release strobes are provided alongside.
//
//   Ports:
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    btn_debounce_if.slave (btn_raw in; btn_clean, press_pulse,
//            release_pulse, long_pulse out)
//
//   Parameters:
//     DEBOUNCE_CYCLES  cycles the synchronised level must hold before a new
//                      level is accepted (>=2)
//     LONG_CYCLES      cycles held pressed before long_pulse (>=2)
//
//   Optional feature macro: LONG_PRESS_EN
//     defined   : long-press counter present, one long_pulse per press
//     undefined : no long counter, long_pulse tied low
// ---------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 200000000
) (
  input  logic           clk,
  input  logic           rst_n,
  btn_debounce_if.slave  bus
);

`ifdef LONG_PRESS_EN
  localparam int MAX_CYC = (LONG_CYCLES > DEBOUNCE_CYCLES) ? LONG_CYCLES : DEBOUNCE_CYCLES;
`else
  localparam int MAX_CYC = DEBOUNCE_CYCLES;
`endif
  localparam int CNT_W = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } state_t;

  // two-flop synchroniser; idle level is high (button released)
  logic s1, btn_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b1;
      btn_s <= 1'b1;
    end else begin
      s1    <= bus.btn_raw;
      btn_s <= s1;
    end
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
      clean_q <= 1'b1;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // cnt only advances while below DB_LAST, so it can never wrap
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      RELEASED: begin
        if (!btn_s) begin
          state_d = PRESS_CHK;
          cnt_d   = '0;
        end
      end
      PRESS_CHK: begin
        if (btn_s) begin
          state_d = RELEASED;               // bounce, drop silently
        end else if (cnt_q == DB_LAST) begin
          state_d = PRESSED;
          clean_d = 1'b0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (btn_s) begin
          state_d = RELEASE_CHK;
          cnt_d   = '0;
        end
      end
      RELEASE_CHK: begin
        if (!btn_s) begin
          state_d = PRESSED;                // bounce, still held
        end else if (cnt_q == DB_LAST) begin
          state_d = RELEASED;
          clean_d = 1'b1;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase
  end

  assign bus.btn_clean     = clean_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = rel_q;

`ifdef LONG_PRESS_EN
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] L_PRE  = CNT_W'(LONG_CYCLES - 2);

  logic [CNT_W-1:0] lcnt_q, lcnt_d;
  logic             long_q, long_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      long_q <= long_d;
    end
  end

  // Pulse is raised on the same edge lcnt reaches L_LAST; lcnt then parks
  // there, which limits it to one long_pulse per press. RELEASE_CHK keeps
  // counting so a release bounce does not restart the long timer.
  always_comb begin
    lcnt_d = lcnt_q;
    long_d = 1'b0;
    if (state_q == PRESS_CHK && state_d == PRESSED) begin
      lcnt_d = '0;
    end else if (state_d == RELEASED) begin
      lcnt_d = '0;
    end else if ((state_q == PRESSED || state_q == RELEASE_CHK) && lcnt_q != L_LAST) begin
      lcnt_d = lcnt_q + CNT_W'(1);
      long_d = (lcnt_q == L_PRE);
    end
  end

  assign bus.long_pulse = long_q;
`else
  assign bus.long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_btn_debounce.sv
module tb_btn_debounce;
  localparam int D = 4;
  localparam int L = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  btn_debounce_if bif();

  btn_debounce #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Reference model: the synchroniser is a 2-sample delay; the accepted
  // level flips once the delayed input has disagreed with it for D+1
  // consecutive samples. Long press fires L-1 edges after the press edge.
  bit mq[$];
  int run, held;
  bit m_clean, m_press, m_rel, m_long, long_done;

  task automatic model_reset();
    mq.delete();
    mq.push_back(1'b1);
    mq.push_back(1'b1);
    run = 0; held = 0; long_done = 1'b0;
    m_clean = 1'b1; m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
  endtask

  task automatic model_edge(input bit raw);
    bit s;
    m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
    s = mq.pop_front();
    mq.push_back(raw);
    if (s != m_clean) run++;
    else run = 0;
    if (run == D + 1) begin
      m_clean = s;
      run = 0;
      if (!s) begin m_press = 1'b1; held = 0; long_done = 1'b0; end
      else m_rel = 1'b1;
    end else if (!m_clean) begin
      held++;
`ifdef LONG_PRESS_EN
      if (held == L - 1 && !long_done) begin m_long = 1'b1; long_done = 1'b1; end
`endif
    end
  endtask

  task automatic step(input bit raw);
    bif.btn_raw = raw;
    @(posedge clk);
    model_edge(raw);
    #1;
  endtask

  task automatic do_reset(input bit raw);
    rst_n = 1'b0;
    bif.btn_raw = raw;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bif.btn_raw = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({bif.btn_clean, bif.press_pulse, bif.release_pulse, bif.long_pulse} !== 4'b1000) begin
        fails++;
        $display("FAIL reset_outputs: got %b expected 1000",
                 {bif.btn_clean, bif.press_pulse, bif.release_pulse, bif.long_pulse});
      end
    end
  endtask

  task automatic test_clean_press();
    do_reset(1'b1);
    repeat (3) step(1'b1);
    for (int e = 1; e <= 8; e++) begin
      step(1'b0);
      if (e <= 6) begin
        tests++;
        if ({bif.btn_clean, bif.press_pulse} !== 2'b10) begin
          fails++;
          $display("FAIL press_early_e%0d: clean/press got %b expected 10", e, {bif.btn_clean, bif.press_pulse});
        end
      end else if (e == 7) begin
        tests++;
        if ({bif.btn_clean, bif.press_pulse} !== 2'b01) begin
          fails++;
          $display("FAIL press_e7: clean/press got %b expected 01", {bif.btn_clean, bif.press_pulse});
        end
      end else begin
        tests++;
        if ({bif.btn_clean, bif.press_pulse} !== 2'b00) begin
          fails++;
          $display("FAIL press_e8: clean/press got %b expected 00", {bif.btn_clean, bif.press_pulse});
        end
      end
    end
  endtask

  task automatic test_bounce();
    do_reset(1'b1);
    repeat (2) step(1'b1);
    for (int i = 0; i < 15; i++) begin
      step(i < 3 ? 1'b0 : 1'b1);
      tests++;
      if ({bif.btn_clean, bif.press_pulse} !== 2'b10) begin
        fails++;
        $display("FAIL bounce_c%0d: clean/press got %b expected 10", i, {bif.btn_clean, bif.press_pulse});
      end
    end
  endtask

  task automatic test_release_bounce();
    int nrel = 0;
    do_reset(1'b1);
    repeat (2) step(1'b1);
    repeat (10) step(1'b0);
    for (int i = 0; i < 7; i++) begin
      step(i < 2 ? 1'b1 : 1'b0);
      nrel += int'(bif.release_pulse);
      tests++;
      if (bif.btn_clean !== 1'b0) begin
        fails++;
        $display("FAIL rel_glitch_c%0d: clean got %b expected 0", i, bif.btn_clean);
      end
    end
    for (int e = 1; e <= 10; e++) begin
      step(1'b1);
      nrel += int'(bif.release_pulse);
      if (e < 7) begin
        tests++;
        if (bif.btn_clean !== 1'b0) begin
          fails++;
          $display("FAIL rel_early_e%0d: clean got %b expected 0", e, bif.btn_clean);
        end
      end else if (e == 7) begin
        tests++;
        if ({bif.btn_clean, bif.release_pulse} !== 2'b11) begin
          fails++;
          $display("FAIL rel_e7: clean/release got %b expected 11", {bif.btn_clean, bif.release_pulse});
        end
      end
    end
    tests++;
    if (nrel != 1) begin
      fails++;
      $display("FAIL rel_count: got %0d release pulses expected 1", nrel);
    end
  endtask

  task automatic test_midcheck_reset();
    int npress = 0;
    do_reset(1'b1);
    repeat (2) step(1'b1);
    repeat (4) begin step(1'b0); npress += int'(bif.press_pulse); end
    rst_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if ({bif.btn_clean, bif.press_pulse, bif.release_pulse} !== 3'b100) begin
      fails++;
      $display("FAIL midreset_outputs: got %b expected 100", {bif.btn_clean, bif.press_pulse, bif.release_pulse});
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step(1'b0);
      if (e <= 6) npress += int'(bif.press_pulse);
      if (e == 6) begin
        tests++;
        if (bif.btn_clean !== 1'b1) begin
          fails++;
          $display("FAIL midreset_e6: clean got %b expected 1", bif.btn_clean);
        end
      end
      if (e == 7) begin
        tests++;
        if ({bif.btn_clean, bif.press_pulse} !== 2'b01) begin
          fails++;
          $display("FAIL midreset_e7: clean/press got %b expected 01", {bif.btn_clean, bif.press_pulse});
        end
      end
    end
    tests++;
    if (npress != 0) begin
      fails++;
      $display("FAIL midreset_nopulse: got %0d early press pulses expected 0", npress);
    end
    repeat (10) step(1'b1);
  endtask

  task automatic test_long_press();
    int press_e = -1, long_e = -1, nlong = 0;
    do_reset(1'b1);
    repeat (2) step(1'b1);
    for (int e = 1; e <= 47; e++) begin
      step(1'b0);
      if (bif.press_pulse === 1'b1 && press_e < 0) press_e = e;
      if (bif.long_pulse === 1'b1) begin nlong++; long_e = e; end
    end
    repeat (10) begin step(1'b1); if (bif.long_pulse === 1'b1) nlong++; end
`ifdef LONG_PRESS_EN
    tests++;
    if (nlong != 1) begin
      fails++;
      $display("FAIL long_count: got %0d long pulses expected 1", nlong);
    end
    tests++;
    if (long_e - press_e != L - 1) begin
      fails++;
      $display("FAIL long_delay: got %0d cycles expected %0d", long_e - press_e, L - 1);
    end
`else
    tests++;
    if (nlong != 0) begin
      fails++;
      $display("FAIL long_disabled: got %0d long pulses expected 0", nlong);
    end
`endif
  endtask

  task automatic test_random();
    bit lvl;
    int len;
    do_reset(1'b1);
    for (int seg = 0; seg < 80; seg++) begin
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 4) == 0) ? $urandom_range(15, 30) : $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        step(lvl);
        tests++;
        if (bif.btn_clean !== m_clean) begin
          fails++;
          $display("FAIL rand_clean s%0d: got %b expected %b", seg, bif.btn_clean, m_clean);
        end
        tests++;
        if (bif.press_pulse !== m_press) begin
          fails++;
          $display("FAIL rand_press s%0d: got %b expected %b", seg, bif.press_pulse, m_press);
        end
        tests++;
        if (bif.release_pulse !== m_rel) begin
          fails++;
          $display("FAIL rand_release s%0d: got %b expected %b", seg, bif.release_pulse, m_rel);
        end
        tests++;
        if (bif.long_pulse !== m_long) begin
          fails++;
          $display("FAIL rand_long s%0d: got %b expected %b", seg, bif.long_pulse, m_long);
        end
        tests++;
        if (bif.press_pulse === 1'b1 && bif.release_pulse === 1'b1) begin
          fails++;
          $display("FAIL rand_exclusive s%0d: press/release got 11 expected not both", seg);
        end
      end
    end
  endtask

  initial begin
    bif.btn_raw = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_midcheck_reset();
    test_long_press();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
